// File: rtl/rs_alu_ctrl.sv
// ALU reservation-station controller: steers two dispatch slots into free entries,
// issues one ready entry per cycle round-robin, and tracks occupancy.
module rs_alu_ctrl #(
    parameter int unsigned ENT_NUM = 8,
    parameter int unsigned ENT_SEL = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ENT_NUM-1:0] i_busy,
    input  logic [ENT_NUM-1:0] i_vld,
    input  logic [1:0]         i_dp_req,
    output logic               o_dp_stall,
    output logic [ENT_NUM-1:0] o_wr_en_0,
    output logic [ENT_NUM-1:0] o_wr_en_1,
    input  logic               i_alu_rdy,
    output logic [ENT_NUM-1:0] o_rd_en,
    output logic [ENT_SEL-1:0] o_rd_idx,
    output logic               o_issue_vld,
    output logic [ENT_SEL-1:0] o_issue_idx,
    output logic [ENT_SEL:0]   o_ocp_cnt
);

    localparam int unsigned CW = ENT_SEL + 1;

    logic [ENT_SEL-1:0] r_rr_ptr;

    logic [ENT_NUM-1:0] w_free;
    logic [ENT_SEL-1:0] w_f0;
    logic [ENT_SEL-1:0] w_f1;
    logic               w_f0_ok;
    logic               w_f1_ok;
    logic [CW-1:0]      w_free_cnt;
    logic [CW-1:0]      w_wr_num;

    logic [ENT_SEL-1:0] w_scan;
    logic [ENT_SEL-1:0] w_sel;
    logic               w_hit;
    logic               w_issue;

    // Two lowest free entries, f1 strictly above f0
    always_comb begin
        w_free  = ~i_busy;
        w_f0    = '0;
        w_f1    = '0;
        w_f0_ok = 1'b0;
        w_f1_ok = 1'b0;
        for (int k = 0; k < ENT_NUM; k++) begin
            if (w_free[k]) begin
                if (!w_f0_ok) begin
                    w_f0    = ENT_SEL'(k);
                    w_f0_ok = 1'b1;
                end else if (!w_f1_ok) begin
                    w_f1    = ENT_SEL'(k);
                    w_f1_ok = 1'b1;
                end
            end
        end
    end

    // Stall uses the registered count, so it is conservative for single requests
    assign w_free_cnt = CW'(ENT_NUM) - o_ocp_cnt;
    assign o_dp_stall = (w_free_cnt < CW'(2));

    assign o_wr_en_0 = (w_f0_ok && i_dp_req[0] && !o_dp_stall) ? (ENT_NUM'(1) << w_f0) : '0;
    assign o_wr_en_1 = (w_f1_ok && i_dp_req[1] && !o_dp_stall) ? (ENT_NUM'(1) << w_f1) : '0;

    // Round-robin search from r_rr_ptr; index arithmetic wraps at ENT_NUM
    always_comb begin
        w_scan = '0;
        w_sel  = '0;
        w_hit  = 1'b0;
        for (int i = 0; i < ENT_NUM; i++) begin
            w_scan = r_rr_ptr + ENT_SEL'(i);
            if (!w_hit && i_vld[w_scan]) begin
                w_sel = w_scan;
                w_hit = 1'b1;
            end
        end
    end

    assign w_issue  = w_hit & i_alu_rdy;
    assign o_rd_en  = w_issue ? (ENT_NUM'(1) << w_sel) : '0;
    assign o_rd_idx = w_issue ? w_sel : r_rr_ptr;

    assign w_wr_num = CW'(|o_wr_en_0) + CW'(|o_wr_en_1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            o_ocp_cnt   <= '0;
            o_issue_vld <= 1'b0;
            o_issue_idx <= '0;
        end else begin
            if (w_issue) begin
                r_rr_ptr    <= w_sel + ENT_SEL'(1);
                o_issue_idx <= w_sel;
            end
            o_issue_vld <= w_issue;
            o_ocp_cnt   <= o_ocp_cnt + w_wr_num - CW'(w_issue);
        end
    end

endmodule

// File: tb/tb_rs_alu_ctrl.sv
// Bench for rs_alu_ctrl: reset-state vector table, directed corner sequences,
// and a randomized station environment checked against a list-based model.
module tb_rs_alu_ctrl;

    localparam int unsigned N = 8;
    localparam int unsigned S = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] i_busy;
    logic [N-1:0] i_vld;
    logic [1:0]   i_dp_req;
    logic         o_dp_stall;
    logic [N-1:0] o_wr_en_0;
    logic [N-1:0] o_wr_en_1;
    logic         i_alu_rdy;
    logic [N-1:0] o_rd_en;
    logic [S-1:0] o_rd_idx;
    logic         o_issue_vld;
    logic [S-1:0] o_issue_idx;
    logic [S:0]   o_ocp_cnt;

    always #5 clk = ~clk;

    rs_alu_ctrl #(.ENT_NUM(N), .ENT_SEL(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_busy      (i_busy),
        .i_vld       (i_vld),
        .i_dp_req    (i_dp_req),
        .o_dp_stall  (o_dp_stall),
        .o_wr_en_0   (o_wr_en_0),
        .o_wr_en_1   (o_wr_en_1),
        .i_alu_rdy   (i_alu_rdy),
        .o_rd_en     (o_rd_en),
        .o_rd_idx    (o_rd_idx),
        .o_issue_vld (o_issue_vld),
        .o_issue_idx (o_issue_idx),
        .o_ocp_cnt   (o_ocp_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int   m_rr;
    int   m_cnt;
    logic m_iv;
    int   m_ii;

    // Station environment and scoreboard
    logic [N-1:0] st_busy;
    logic [N-1:0] st_rdy;
    int           tag [N];
    int           n_disp;
    int           n_iss;
    int           n_bad;
    bit           seen [int];

    // Values sampled from the DUT in the latest cycle
    logic [N-1:0] s_wr0, s_wr1, s_rd;
    logic         s_stall, s_iv;
    logic [S-1:0] s_idx, s_iidx;
    logic [S:0]   s_cnt;

    typedef struct {
        logic [N-1:0] busy;
        logic [N-1:0] vld;
        logic [1:0]   req;
        logic         rdy;
        logic         stall;
        logic [N-1:0] wr0;
        logic [N-1:0] wr1;
        logic [N-1:0] rd;
        logic [S-1:0] idx;
    } vec_t;

    vec_t tv [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        st_busy   = '0;
        st_rdy    = '0;
        i_busy    = '0;
        i_vld     = '0;
        i_dp_req  = '0;
        i_alu_rdy = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_rr  = 0;
        m_cnt = 0;
        m_iv  = 1'b0;
        m_ii  = 0;
    endtask

    // One clock: drive station state, check against the model, advance both
    task automatic run_cycle(input logic [1:0] req, input logic rdy);
        int           fq[$];
        logic [N-1:0] vld, e_wr0, e_wr1, e_rd;
        logic         e_stall;
        int           e_idx;
        int           k;
        vld       = st_busy & st_rdy;
        i_busy    = st_busy;
        i_vld     = vld;
        i_dp_req  = req;
        i_alu_rdy = rdy;
        #2;
        for (int j = 0; j < N; j++) if (!st_busy[j]) fq.push_back(j);
        e_stall = (int'(N) - m_cnt) < 2;
        e_wr0 = '0;
        e_wr1 = '0;
        if (req[0] && !e_stall && fq.size() > 0) e_wr0[fq[0]] = 1'b1;
        if (req[1] && !e_stall && fq.size() > 1) e_wr1[fq[1]] = 1'b1;
        e_rd  = '0;
        e_idx = m_rr;
        if (rdy) begin
            for (int i = 0; i < N; i++) begin
                k = (m_rr + i) % N;
                if (vld[k]) begin
                    e_rd[k] = 1'b1;
                    e_idx   = k;
                    break;
                end
            end
        end
        s_wr0 = o_wr_en_0; s_wr1 = o_wr_en_1; s_rd = o_rd_en;
        s_stall = o_dp_stall; s_idx = o_rd_idx; s_iv = o_issue_vld;
        s_iidx = o_issue_idx; s_cnt = o_ocp_cnt;
        chk("stall", s_stall, e_stall);
        chk("wr_en_0", s_wr0, e_wr0);
        chk("wr_en_1", s_wr1, e_wr1);
        chk("rd_en", s_rd, e_rd);
        chk("rd_idx", s_idx, e_idx);
        chk("issue_vld", s_iv, m_iv);
        if (m_iv) chk("issue_idx", s_iidx, m_ii);
        chk("ocp_cnt", s_cnt, m_cnt);
        chk("ocp_eq_busy", s_cnt, $countones(st_busy));
        chk("onehot0", {$onehot0(s_wr0), $onehot0(s_wr1), $onehot0(s_rd)}, 3'b111);
        chk("overlap", (s_wr0 & s_wr1) | (s_rd & (s_wr0 | s_wr1)), 0);
        @(posedge clk);
        if (|e_rd) begin
            m_rr = (e_idx + 1) % N;
            m_ii = e_idx;
        end
        m_iv  = |e_rd;
        m_cnt = m_cnt + $countones(e_wr0 | e_wr1) - ((|e_rd) ? 1 : 0);
        for (int j = 0; j < N; j++) begin
            if (s_rd[j]) begin
                if (!(st_busy[j] && st_rdy[j])) n_bad++;
                else if (seen.exists(tag[j])) n_bad++;
                else begin
                    seen[tag[j]] = 1'b1;
                    n_iss++;
                end
                st_busy[j] = 1'b0;
                st_rdy[j]  = 1'b0;
            end
            if (s_wr0[j] || s_wr1[j]) begin
                if (st_busy[j]) n_bad++;
                st_busy[j] = 1'b1;
                st_rdy[j]  = 1'b0;
                tag[j]     = n_disp;
                n_disp++;
            end
        end
        #1;
    endtask

    task automatic rand_cycle();
        int r;
        logic [1:0] req;
        for (int j = 0; j < N; j++)
            if (st_busy[j] && !st_rdy[j] && $urandom_range(0, 2) == 0) st_rdy[j] = 1'b1;
        r   = $urandom_range(0, 3);
        req = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
        run_cycle(req, ($urandom_range(0, 3) != 0));
    endtask

    initial begin
        // Held in reset: rr_ptr=0, count=0, so outputs are pure functions of inputs
        tv[0] = '{8'h00, 8'h00, 2'b11, 1'b1, 1'b0, 8'h01, 8'h02, 8'h00, 3'd0};
        tv[1] = '{8'h05, 8'h04, 2'b11, 1'b1, 1'b0, 8'h02, 8'h08, 8'h04, 3'd2};
        tv[2] = '{8'h05, 8'h04, 2'b01, 1'b0, 1'b0, 8'h02, 8'h00, 8'h00, 3'd0};
        tv[3] = '{8'h05, 8'h05, 2'b10, 1'b1, 1'b0, 8'h00, 8'h08, 8'h01, 3'd0};
        tv[4] = '{8'h7F, 8'h60, 2'b11, 1'b1, 1'b0, 8'h80, 8'h00, 8'h20, 3'd5};
        tv[5] = '{8'hF0, 8'hC0, 2'b00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h40, 3'd6};
        tv[6] = '{8'hFE, 8'h80, 2'b11, 1'b1, 1'b0, 8'h01, 8'h00, 8'h80, 3'd7};
        tv[7] = '{8'hAA, 8'h0A, 2'b11, 1'b1, 1'b0, 8'h01, 8'h04, 8'h02, 3'd1};

        n_disp = 0; n_iss = 0; n_bad = 0;
        rst_n = 1'b0; i_busy = '0; i_vld = '0; i_dp_req = '0; i_alu_rdy = 1'b0;
        @(posedge clk);
        #1;
        for (int v = 0; v < 8; v++) begin
            i_busy = tv[v].busy; i_vld = tv[v].vld; i_dp_req = tv[v].req; i_alu_rdy = tv[v].rdy;
            #2;
            chk("tv_stall", o_dp_stall, tv[v].stall);
            chk("tv_wr0", o_wr_en_0, tv[v].wr0);
            chk("tv_wr1", o_wr_en_1, tv[v].wr1);
            chk("tv_rd", o_rd_en, tv[v].rd);
            chk("tv_idx", o_rd_idx, tv[v].idx);
            chk("tv_rst_state", {o_ocp_cnt, o_issue_vld}, 0);
            @(posedge clk);
            #1;
        end

        do_reset();
        // First dispatch into an empty station, then fill to 7
        run_cycle(2'b11, 1'b1);
        chk("tp_first_wr0", s_wr0, 8'h01);
        chk("tp_first_wr1", s_wr1, 8'h02);
        run_cycle(2'b11, 1'b0);
        chk("tp_cnt2", s_cnt, 2);
        run_cycle(2'b11, 1'b0);
        run_cycle(2'b01, 1'b0);
        chk("tp_six_nostall", s_stall, 1'b0);
        run_cycle(2'b01, 1'b0);
        chk("tp_seven_stall", s_stall, 1'b1);
        chk("tp_seven_wr", {s_wr0, s_wr1}, 0);
        chk("tp_seven_cnt", s_cnt, 7);

        // Round-robin wrap from pointer 7
        st_rdy[6] = 1'b1;
        run_cycle(2'b00, 1'b1);
        chk("tp_issue6", s_rd, 8'h40);
        run_cycle(2'b11, 1'b0);
        chk("tp_refill", {s_wr0, s_wr1}, {8'h40, 8'h80});
        st_rdy[0] = 1'b1; st_rdy[7] = 1'b1;
        run_cycle(2'b00, 1'b1);
        chk("tp_wrap_rd", s_rd, 8'h80);
        run_cycle(2'b00, 1'b1);
        chk("tp_wrap_next", s_rd, 8'h01);
        chk("tp_wrap_ivld", s_iv, 1'b1);
        chk("tp_wrap_iidx", s_iidx, 3'd7);

        // Back-pressure holds pointer and count
        run_cycle(2'b00, 1'b0);
        st_rdy[4] = 1'b1;
        repeat (3) begin
            run_cycle(2'b00, 1'b0);
            chk("tp_bp_rd", s_rd, 0);
            chk("tp_bp_ivld", s_iv, 1'b0);
            chk("tp_bp_ptr", s_idx, 3'd1);
            chk("tp_bp_cnt", s_cnt, 6);
        end
        run_cycle(2'b00, 1'b1);
        chk("tp_bp_release", s_rd, 8'h10);

        // Two allocations and one issue in the same cycle
        st_rdy[5] = 1'b1;
        run_cycle(2'b00, 1'b1);
        st_rdy[1] = 1'b1;
        run_cycle(2'b11, 1'b1);
        chk("tp_sim_cnt_before", s_cnt, 4);
        chk("tp_sim_rd", s_rd, 8'h02);
        run_cycle(2'b00, 1'b0);
        chk("tp_sim_cnt_after", s_cnt, 5);

        repeat (10000) rand_cycle();

        // Drain and verify every dispatched instruction issued exactly once
        for (int t = 0; t < 64 && st_busy != '0; t++) begin
            st_rdy = st_busy;
            run_cycle(2'b00, 1'b1);
        end
        chk("drain_empty", st_busy, 0);
        chk("issued_total", n_iss, n_disp);
        chk("sb_errors", n_bad, 0);

        // Reset in the middle of traffic discards state
        repeat (20) rand_cycle();
        do_reset();
        run_cycle(2'b00, 1'b0);
        chk("mid_rst_cnt", s_cnt, 0);
        chk("mid_rst_ivld", s_iv, 1'b0);
        chk("mid_rst_ptr", s_idx, 3'd0);
        chk("mid_rst_stall", s_stall, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
